wb_unit: RTL
============

WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning result-queue entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports mem_valid/mem_ready  input/output  1/1, mem_rd  input  5, mem_data  input  32: load/multicycle result channel.
REQ-005 SHALL have ports ex_valid/ex_ready  input/output  1/1, ex_rd  input  5, ex_data  input  32: single-cycle ALU result channel.
REQ-006 SHALL have port wb_hold  input  1  stalls regfile writeback when high.
REQ-007 SHALL have ports WE  output  1, writePortSEL  output  5, writePort  output  32: drive the register file write port.
REQ-008 SHALL have ports readPort1SEL/readPort2SEL  input  5  decode-stage source selects.
REQ-009 SHALL have ports fwd1_hit/fwd2_hit  output  1, fwd1_data/fwd2_data  output  32: bypass of queued, unwritten results.
REQ-010 SHALL have ports empty  output  1, full  output  1, count  output  $clog2(DEPTH)+1: queue status.

Function
REQ-011 Queue SHALL be an in-order FIFO of {rd, data}; a transfer occurs on a channel when valid && ready at posedge clk.
REQ-012 pop SHALL be !empty && !wb_hold; WE = pop; writePortSEL/writePort = head entry, combinational from head (zero when empty).
REQ-013 Head SHALL dequeue on every posedge where pop is high (write lands on the following negedge in the register file).
REQ-014 free SHALL equal DEPTH - count + pop; mem_ready = (free >= 1); ex_ready = (free >= (mem_valid ? 2 : 1)).
REQ-015 Ready SHALL NOT depend on the rd fields.
REQ-016 When both channels transfer in one cycle, the mem entry SHALL be enqueued ahead of the ex entry (mem is older).
REQ-017 A transfer with rd == 0 SHALL be accepted and discarded (not enqueued, count unchanged by it).
REQ-018 count SHALL update as count + pushes - pop, with pushes in 0..2; full = (count == DEPTH); empty = (count == 0).
REQ-019 Read/write pointers SHALL wrap modulo DEPTH with no gap or duplicate entry.
REQ-020 fwdN_hit SHALL be high when readPortNSEL != 0 and some valid queued entry has rd == readPortNSEL; fwdN_data = data of the youngest such entry.
REQ-021 Forwarding SHALL search current queue contents only (including head being written this cycle), not same-cycle incoming transfers.
REQ-022 With readPortNSEL == 0 or no match: fwdN_hit = 0, fwdN_data = 0.

Reset
REQ-023 rst high SHALL immediately clear pointers and count: empty = 1, full = 0, WE = 0, fwd hits = 0, ready reflect an empty queue.
REQ-024 Reset mid-operation SHALL drop all queued entries without any WE pulse; storage array SHALL NOT be reset.

Configuration
REQ-025 Macro WB_FWD_EN SHALL compile in the forwarding search; when undefined fwd1_hit/fwd2_hit/fwd1_data/fwd2_data SHALL be tied to 0 and no compare logic built.

Structure
REQ-026 Shared package wb_pkg SHALL hold the wb_entry_t typedef {rd[4:0], data[31:0]}, REG_ZERO = 5'd0 and XLEN = 32.
REQ-027 Forwarding match SHALL be one sub-module wb_fwd_match (queue contents + select -> hit, data), instantiated twice.

Verification
REQ-028 Reset, then mem push {rd=5, 0xDEAD_BEEF}, wb_hold=0 -> next cycle WE=1, writePortSEL=5, writePort=0xDEADBEEF; then empty=1.
REQ-029 wb_hold=1, push mem and ex in same cycle (rd 3/0x11, rd 4/0x22) -> count=2, head rd=3; release hold -> writes rd3 then rd4 on consecutive cycles.
REQ-030 wb_hold=1, DEPTH=4, fill to count=3, mem_valid=ex_valid=1 -> mem_ready=1, ex_ready=0; next cycle full=1, mem_ready=0.
REQ-031 Queue holds rd=7/0x1 then rd=7/0x2, readPort1SEL=7 -> fwd1_hit=1, fwd1_data=0x2; readPort2SEL=0 -> fwd2_hit=0.
REQ-032 ex push rd=0 -> ex_ready=1, count stays 0, no WE; rst asserted with count=3 -> count=0, WE=0 immediately.
REQ-033 Build without WB_FWD_EN, repeat REQ-031 stimulus -> fwd1_hit=0, fwd1_data=0.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the writeback queue slice.
//   wb_entry_t : one queued register-file write {rd, data}
//   REG_ZERO   : architectural zero register; writes to it are discarded
//   XLEN       : register data width
package wb_pkg;

   localparam int XLEN = 32;
   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// wb_fwd_match: searches queued writeback entries for a register select.
// Ports:
//   entries : queue contents in age order, index 0 = oldest (head)
//   valid   : per-slot occupancy mask, same ordering as entries
//   sel     : decode-stage source register select
//   hit     : some valid entry targets sel (never for the zero register)
//   data    : data of the youngest matching entry, zero when no hit
module wb_fwd_match
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  wb_entry_t [DEPTH-1:0] entries,
   input  logic [DEPTH-1:0]      valid,
   input  logic [4:0]            sel,
   output logic                  hit,
   output logic [XLEN-1:0]       data
);

   // Walking oldest to youngest lets the last match win, which gives the
   // youngest pending value without an explicit priority encoder.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      if (sel != REG_ZERO) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (entries[i].rd == sel)) begin
               hit  = 1'b1;
               data = entries[i].data;
            end
         end
      end
   end

endmodule

// File: rtl/wb_unit.sv
// wb_unit: in-order writeback queue merging a load/multicycle result channel
// (mem_*) and a single-cycle ALU channel (ex_*) into one register file write
// port, with optional bypass of queued, not-yet-written results.
// Ports:
//   clk, rst                          : clock, async active-high reset
//   mem_valid/mem_ready/mem_rd/mem_data : older result channel
//   ex_valid/ex_ready/ex_rd/ex_data     : younger result channel
//   wb_hold                           : stalls the register file write
//   WE, writePortSEL, writePort       : register file write port (head entry)
//   readPort1SEL/readPort2SEL         : decode source selects for bypass
//   fwd1_hit/fwd1_data/fwd2_hit/fwd2_data : bypass results
//   empty, full, count                : queue status
// Configuration macro: WB_FWD_EN builds the bypass search; without it the
// fwd outputs are tied to zero.
module wb_unit
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   mem_valid,
   output logic                   mem_ready,
   input  logic [4:0]             mem_rd,
   input  logic [XLEN-1:0]        mem_data,
   input  logic                   ex_valid,
   output logic                   ex_ready,
   input  logic [4:0]             ex_rd,
   input  logic [XLEN-1:0]        ex_data,
   input  logic                   wb_hold,
   output logic                   WE,
   output logic [4:0]             writePortSEL,
   output logic [XLEN-1:0]        writePort,
   input  logic [4:0]             readPort1SEL,
   input  logic [4:0]             readPort2SEL,
   output logic                   fwd1_hit,
   output logic [XLEN-1:0]        fwd1_data,
   output logic                   fwd2_hit,
   output logic [XLEN-1:0]        fwd2_data,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int FW = CW + 1;

   wb_entry_t     store_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] ex_slot;
   logic [FW-1:0] free;
   logic          pop, mem_push, ex_push;
   wb_entry_t     head;

   // Readiness counts the slot freed by this cycle's pop, and reserves a
   // slot for mem whenever mem is offering so the older result never loses
   // its place to ex. It deliberately ignores rd so ready has no data path.
   always_comb begin
      pop       = (count_q != '0) && !wb_hold;
      free      = FW'(DEPTH) - FW'(count_q) + FW'(pop);
      mem_ready = (free >= FW'(1));
      ex_ready  = (free >= (mem_valid ? FW'(2) : FW'(1)));
      mem_push  = mem_valid && mem_ready && (mem_rd != REG_ZERO);
      ex_push   = ex_valid && ex_ready && (ex_rd != REG_ZERO);
      ex_slot   = mem_push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
      wr_ptr_d  = wr_ptr_q + AW'(mem_push) + AW'(ex_push);
      rd_ptr_d  = rd_ptr_q + AW'(pop);
      count_d   = count_q + CW'(mem_push) + CW'(ex_push) - CW'(pop);
   end

   // Pointer and occupancy state; clearing these is enough to drop every
   // queued entry, so the storage itself is left unreset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; mem lands ahead of ex when both push in one cycle.
   always_ff @(posedge clk) begin
      if (mem_push) store_q[wr_ptr_q] <= '{rd: mem_rd, data: mem_data};
      if (ex_push)  store_q[ex_slot]  <= '{rd: ex_rd, data: ex_data};
   end

   // Write port is the head entry; forced to zero when empty because the
   // unreset storage may hold stale or undefined contents.
   always_comb begin
      head         = store_q[rd_ptr_q];
      WE           = pop;
      writePortSEL = (count_q == '0) ? REG_ZERO : head.rd;
      writePort    = (count_q == '0) ? '0 : head.data;
      empty        = (count_q == '0);
      full         = (count_q == CW'(DEPTH));
      count        = count_q;
   end

`ifdef WB_FWD_EN
   wb_entry_t [DEPTH-1:0] age_entries;
   logic [DEPTH-1:0]      age_valid;

   // Rotate storage so index 0 is the head; the matcher then only needs
   // a simple oldest-to-youngest scan.
   always_comb begin
      age_entries = '0;
      age_valid   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         age_entries[i] = store_q[rd_ptr_q + AW'(i)];
         age_valid[i]   = (CW'(i) < count_q);
      end
   end

   wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
      .entries(age_entries),
      .valid  (age_valid),
      .sel    (readPort1SEL),
      .hit    (fwd1_hit),
      .data   (fwd1_data)
   );

   wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
      .entries(age_entries),
      .valid  (age_valid),
      .sel    (readPort2SEL),
      .hit    (fwd2_hit),
      .data   (fwd2_data)
   );
`else
   logic unused_fwd_sel;

   assign unused_fwd_sel = ^{readPort1SEL, readPort2SEL};
   assign fwd1_hit  = 1'b0;
   assign fwd1_data = '0;
   assign fwd2_hit  = 1'b0;
   assign fwd2_data = '0;
`endif

endmodule
